// File: rtl/sobel_pkg.sv
// sobel_pkg: shared Sobel kernels, width helper and stage payload for sobel_pipe.
package sobel_pkg;
  localparam int PAY_W = 32;
  localparam int signed KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int signed KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
  typedef struct packed {
    logic signed [PAY_W-1:0] gx;
    logic signed [PAY_W-1:0] gy;
    logic [PAY_W-1:0] thr;
  } grad_t;
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction
  function automatic logic [PAY_W-1:0] abs_pay(input logic signed [PAY_W-1:0] v);
    return v[PAY_W-1] ? PAY_W'(-v) : PAY_W'(v);
  endfunction
endpackage

// File: rtl/sobel_frame_ctr.sv
// sobel_frame_ctr: counts output transfers per frame, tallies edges, pulses sobel_done.
module sobel_frame_ctr #(
  parameter int FRAME_PIX = 16,
  localparam int CNT_W = $clog2(FRAME_PIX + 1),
  localparam int PIX_CW = $clog2(FRAME_PIX)
) (
  input logic clk,
  input logic rst,
  input logic xfer,
  input logic is_edge,
  output logic [CNT_W-1:0] edge_count,
  output logic sobel_done
);
  logic [PIX_CW-1:0] pix_cnt;
  logic last;
  assign last = pix_cnt == PIX_CW'(FRAME_PIX - 1);
  // edge_count survives past the frame end and is restarted by the first pixel of the next frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pix_cnt <= '0;
      edge_count <= '0;
      sobel_done <= 1'b0;
    end else begin
      sobel_done <= xfer & last;
      if (xfer) begin
        pix_cnt <= last ? '0 : pix_cnt + 1'b1;
        edge_count <= (pix_cnt == '0 ? '0 : edge_count) + CNT_W'(is_edge);
      end
    end
endmodule

// File: rtl/sobel_pipe.sv
// sobel_pipe: 3-stage Sobel gradient / edge-detect pipeline with valid-ready handshakes.
module sobel_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int FRAME_PIX = 16,
  localparam int GRAD_W = grad_w(PIX_W),
  localparam int CNT_W = $clog2(FRAME_PIX + 1)
) (
  input logic clk,
  input logic rst,
  input logic in_valid,
  output logic in_ready,
  input logic [2:0][2:0][PIX_W-1:0] comp_matrix,
  input logic [GRAD_W-1:0] threshold,
  output logic out_valid,
  input logic out_ready,
  output logic output_pixel,
  output logic [PIX_W-1:0] out_mag,
  output logic [CNT_W-1:0] edge_count,
  output logic sobel_done
);
  if (GRAD_W > PAY_W) begin : g_w_chk
    $error("sobel_pipe: PIX_W too wide for stage payload");
  end
  if (FRAME_PIX < 2) begin : g_f_chk
    $error("sobel_pipe: FRAME_PIX must be at least 2");
  end
  logic signed [GRAD_W-1:0] gx, gy;
  logic advance, s1_vld, s2_vld;
  grad_t s1;
  logic [PAY_W-1:0] s2_sum, s2_thr;
  always_comb begin
    gx = '0;
    gy = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        gx = gx + GRAD_W'(KX[r][c]) * $signed(GRAD_W'(comp_matrix[r][c]));
        gy = gy + GRAD_W'(KY[r][c]) * $signed(GRAD_W'(comp_matrix[r][c]));
      end
  end
  // single global enable: every stage moves unless a held result is blocking the output
  assign advance = ~out_valid | out_ready;
  assign in_ready = advance;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      out_valid <= 1'b0;
      output_pixel <= 1'b0;
      out_mag <= '0;
      s1 <= '0;
      s2_sum <= '0;
      s2_thr <= '0;
    end else if (advance) begin
      s1_vld <= in_valid;
      s1 <= '{gx: PAY_W'(gx), gy: PAY_W'(gy), thr: PAY_W'(threshold)};
      s2_vld <= s1_vld;
      s2_sum <= abs_pay(s1.gx) + abs_pay(s1.gy);
      s2_thr <= s1.thr;
      out_valid <= s2_vld;
      output_pixel <= s2_sum > s2_thr;
      out_mag <= |(s2_sum >> PIX_W) ? '1 : s2_sum[PIX_W-1:0];
    end
  sobel_frame_ctr #(.FRAME_PIX(FRAME_PIX)) u_ctr (
    .clk(clk),
    .rst(rst),
    .xfer(out_valid & out_ready),
    .is_edge(output_pixel),
    .edge_count(edge_count),
    .sobel_done(sobel_done)
  );
endmodule

// File: tb/tb_sobel_pipe.sv
// tb_sobel_pipe: directed self-checking bench for sobel_pipe (PIX_W=8, FRAME_PIX=4).
module tb_sobel_pipe;
  typedef logic [2:0][2:0][7:0] win_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  win_t comp_matrix = '0;
  logic [10:0] threshold = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic output_pixel;
  logic [7:0] out_mag;
  logic [2:0] edge_count;
  logic sobel_done;
  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int n_done = 0;
  logic [2:0] done_ec = '0;
  logic [8:0] exp_q[$];
  logic acc;
  int k;
  win_t ones, px;

  sobel_pipe #(.PIX_W(8), .FRAME_PIX(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .comp_matrix(comp_matrix), .threshold(threshold), .out_valid(out_valid),
    .out_ready(out_ready), .output_pixel(output_pixel), .out_mag(out_mag),
    .edge_count(edge_count), .sobel_done(sobel_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic win_t cols(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
    win_t w;
    for (int i = 0; i < 3; i++) begin
      w[i][0] = l; w[i][1] = m; w[i][2] = r;
    end
    return w;
  endfunction

  function automatic win_t rows(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    win_t w;
    for (int j = 0; j < 3; j++) begin
      w[0][j] = t; w[1][j] = m; w[2][j] = b;
    end
    return w;
  endfunction

  // one cycle: drive at negedge, then score what the next posedge will transfer
  task automatic cyc(input logic iv, input win_t w, input logic [10:0] th, input logic ordy,
                     input logic e_edge, input logic [7:0] e_mag, output logic a);
    logic [8:0] e;
    @(negedge clk);
    in_valid = iv; comp_matrix = w; threshold = th; out_ready = ordy;
    #1;
    a = iv & in_ready;
    if (a) exp_q.push_back({e_edge, e_mag});
    if (sobel_done) begin
      n_done++;
      done_ec = edge_count;
    end
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("edge", output_pixel, e[8]);
        chk("mag", out_mag, e[7:0]);
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) cyc(0, '0, '0, ordy, 0, 0, a);
  endtask

  initial begin
    ones = cols(8'd1, 8'd1, 8'd1);
    px = '0;
    px[2][2] = 8'd100;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_done", sobel_done, 0);
    chk("rst_mag", out_mag, 0);
    chk("rst_pixel", output_pixel, 0);
    @(negedge clk) rst = 1'b0;

    cyc(1, ones, 11'd0, 1, 0, 8'd0, acc);
    chk("lat_accept", acc, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, '0, '0, 1, 0, 0, acc);
      chk("latency", out_valid, i == 3);
    end
    idle(2, 1);

    cyc(1, cols(8'd0, 8'd128, 8'd255), 11'd500, 1, 1, 8'd255, acc);
    cyc(1, cols(8'd255, 8'd0, 8'd0), 11'd0, 1, 1, 8'd255, acc);
    cyc(1, rows(8'd0, 8'd5, 8'd10), 11'd40, 1, 0, 8'd40, acc);
    cyc(1, rows(8'd0, 8'd5, 8'd10), 11'd39, 1, 1, 8'd40, acc);
    cyc(1, px, 11'd199, 1, 1, 8'd200, acc);
    cyc(1, px, 11'd200, 1, 0, 8'd200, acc);
    idle(5, 1);
    chk("vec_outputs", n_out, 7);

    n_out = 0;
    k = 1;
    for (int c = 0; c < 40 && (k <= 6 || exp_q.size() != 0); c++) begin
      cyc(k <= 6, cols(8'd0, 8'd0, 8'(k)), 11'd2047, !(c >= 4 && c < 9), 0, 8'(4 * k), acc);
      if (acc) k++;
    end
    chk("stall_accepted", k - 1, 6);
    chk("stall_drained", exp_q.size(), 0);
    chk("stall_outputs", n_out, 6);

    @(negedge clk) rst = 1'b1;
    #1 rst = 1'b0;
    n_done = 0;
    cyc(1, rows(8'd0, 8'd5, 8'd10), 11'd40, 1, 0, 8'd40, acc);
    cyc(1, rows(8'd0, 8'd5, 8'd10), 11'd39, 1, 1, 8'd40, acc);
    cyc(1, rows(8'd0, 8'd5, 8'd10), 11'd40, 1, 0, 8'd40, acc);
    cyc(1, rows(8'd0, 8'd5, 8'd10), 11'd39, 1, 1, 8'd40, acc);
    idle(6, 1);
    chk("frame_done_count", n_done, 1);
    chk("frame_done_edges", done_ec, 2);
    chk("frame_hold_edges", edge_count, 2);
    cyc(1, rows(8'd0, 8'd5, 8'd10), 11'd39, 1, 1, 8'd40, acc);
    idle(4, 1);
    chk("next_frame_edges", edge_count, 1);
    chk("next_frame_done", n_done, 1);

    cyc(1, cols(8'd0, 8'd0, 8'd10), 11'd2047, 0, 0, 8'd40, acc);
    cyc(1, cols(8'd0, 8'd0, 8'd10), 11'd2047, 0, 0, 8'd40, acc);
    cyc(1, cols(8'd0, 8'd0, 8'd10), 11'd2047, 0, 0, 8'd40, acc);
    idle(1, 0);
    chk("pre_rst_stalled", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_mag", out_mag, 0);
    chk("arst_pixel", output_pixel, 0);
    chk("arst_edge_count", edge_count, 0);
    chk("arst_done", sobel_done, 0);
    chk("arst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    n_out = 0;
    n_done = 0;
    idle(8, 1);
    chk("post_rst_outputs", n_out, 0);
    chk("post_rst_done", n_done, 0);
    cyc(1, px, 11'd199, 1, 1, 8'd200, acc);
    idle(4, 1);
    chk("post_rst_new", n_out, 1);
    chk("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
